// File: rtl/spi_mem_master.sv
// spi_mem_master: turns one parallel request (op + byte) into one SPI frame
// for the memory wrapper's SPI slave, and collects the MISO byte on read-data.
//
// Ports:
//   clk      system clock, all logic on the rising edge
//   rst_n    synchronous active-low reset (aborts any frame in progress)
//   start    request strobe, accepted only while busy=0
//   op       00 write-addr, 01 write-data, 10 read-addr, 11 read-data
//   din      address/data byte (ignored for op 11, which sends 8'hFF)
//   busy     high from the cycle after acceptance until back in idle
//   done     one-cycle pulse on the first SS_n-high cycle after a frame
//   rd_data  byte returned by op 11, held until the next op-11 done
//   SS_n     slave select, active low
//   MOSI     serial out, MSB first
//   MISO     serial in, sampled only while receiving
module spi_mem_master #(
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned RX_DELAY   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] din,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  // One timer serves both the WAIT and GAP phases.
  localparam int unsigned TMAX = (GAP_CYCLES > RX_DELAY) ? GAP_CYCLES : RX_DELAY;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(RX_DELAY - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_SHIFT,
    ST_WAIT,
    ST_RECV,
    ST_END,
    ST_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [7:0]      pay_q, pay_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            ss_n_q, ss_n_d;
  logic            mosi_q, mosi_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [9:0]      frame;
  logic [3:0]      cnt_nxt;

  always_comb begin
    frame     = {op_q, pay_q};
    cnt_nxt   = cnt_q + 4'd1;

    state_d   = state_q;
    op_d      = op_q;
    pay_d     = pay_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    shreg_d   = shreg_q;
    rd_data_d = rd_data_q;
    ss_n_d    = ss_n_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    // Outputs are registered, so each branch sets the values for the
    // state being entered rather than the state currently held.
    case (state_q)
      ST_IDLE: begin
        ss_n_d = 1'b1;
        mosi_d = 1'b0;
        busy_d = 1'b0;
        cnt_d  = '0;
        tmr_d  = '0;
        if (start) begin
          op_d    = op;
          pay_d   = (op == 2'b11) ? 8'hFF : din;
          state_d = ST_SEL;
          ss_n_d  = 1'b0;
          busy_d  = 1'b1;
          mosi_d  = op[1];
        end
      end

      ST_SEL: begin
        state_d = ST_SHIFT;
        cnt_d   = '0;
        mosi_d  = frame[9];
      end

      ST_SHIFT: begin
        if (cnt_q == 4'd9) begin
          cnt_d = '0;
          tmr_d = '0;
          if (op_q == 2'b11) begin
            state_d = (RX_DELAY > 0) ? ST_WAIT : ST_RECV;
            mosi_d  = 1'b1;
          end else begin
            state_d = ST_END;
            mosi_d  = 1'b0;
          end
        end else begin
          cnt_d  = cnt_nxt;
          mosi_d = frame[4'd9 - cnt_nxt];
        end
      end

      ST_WAIT: begin
        mosi_d = 1'b1;
        if (tmr_q == WAIT_LAST) begin
          state_d = ST_RECV;
          tmr_d   = '0;
          cnt_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      ST_RECV: begin
        shreg_d = {shreg_q[6:0], MISO};
        if (cnt_q == 4'd7) begin
          state_d = ST_END;
          cnt_d   = '0;
          mosi_d  = 1'b0;
        end else begin
          cnt_d  = cnt_nxt;
          mosi_d = 1'b1;
        end
      end

      ST_END: begin
        state_d = ST_GAP;
        ss_n_d  = 1'b1;
        mosi_d  = 1'b0;
        done_d  = 1'b1;
        tmr_d   = '0;
        if (op_q == 2'b11) begin
          rd_data_d = shreg_q;
        end
      end

      ST_GAP: begin
        if (tmr_q == GAP_LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        ss_n_d  = 1'b1;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      pay_q     <= '0;
      cnt_q     <= '0;
      tmr_q     <= '0;
      shreg_q   <= '0;
      rd_data_q <= '0;
      ss_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      pay_q     <= pay_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      shreg_q   <= shreg_d;
      rd_data_q <= rd_data_d;
      ss_n_q    <= ss_n_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_data = rd_data_q;
  assign SS_n    = ss_n_q;
  assign MOSI    = mosi_q;

endmodule

// File: tb/tb_spi_mem_master.sv
// Testbench for spi_mem_master: a behavioural SPI memory slave answers the
// master's frames, and a reference model predicts each frame's serial shape
// and the returned read data.
module tb_spi_mem_master;

  localparam int unsigned GAP = 1;
  localparam int unsigned RXD = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] op;
  logic [7:0] din;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_mem_master #(
    .GAP_CYCLES(GAP),
    .RX_DELAY  (RXD)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .din    (din),
    .busy   (busy),
    .done   (done),
    .rd_data(rd_data),
    .SS_n   (SS_n),
    .MOSI   (MOSI),
    .MISO   (MISO)
  );

  // ---------------- behavioural SPI memory slave ----------------
  logic [7:0]  slv_mem [256];
  logic [7:0]  slv_wa;
  logic [7:0]  slv_ra;
  logic [63:0] fbits = '0;
  int unsigned scnt  = 0;
  logic [5:0]  sidx;
  logic [2:0]  bidx;
  logic [7:0]  rd_byte;
  logic        is_rd;
  logic [7:0]  fpay;

  assign sidx    = 6'(scnt);
  assign bidx    = 3'(18 + RXD - scnt);
  assign rd_byte = slv_mem[slv_ra];
  assign is_rd   = fbits[1] & fbits[2];
  assign fpay    = {fbits[3], fbits[4], fbits[5], fbits[6],
                    fbits[7], fbits[8], fbits[9], fbits[10]};

  // Frame bit 0 is the select bit, 1..2 the op, 3..10 the payload.
  always @(negedge clk) begin
    if (SS_n === 1'b0) begin
      if (scnt < 64) begin
        fbits[sidx] <= MOSI;
        scnt        <= scnt + 1;
      end
      if (is_rd && scnt >= 11 + RXD && scnt <= 18 + RXD)
        MISO <= rd_byte[bidx];
      else
        MISO <= 1'($urandom);
    end else begin
      MISO <= 1'($urandom);
      if (scnt == 12) begin
        case ({fbits[1], fbits[2]})
          2'b00:   slv_wa <= fpay;
          2'b01:   slv_mem[slv_wa] <= fpay;
          2'b10:   slv_ra <= fpay;
          default: ;
        endcase
      end
      scnt <= 0;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [256];
  logic [7:0] ref_wa = '0;
  logic [7:0] ref_ra = '0;
  logic [7:0] ref_rd = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request and watches it to the return to idle.
  task automatic run_frame(input logic [1:0] f_op, input logic [7:0] f_din, input bit keep);
    logic [63:0] ss_v, mo_v, dn_v, bz_v, ss_e, mo_e, dn_e, bz_e;
    logic [7:0]  pay, rd_exp, rd_done;
    int unsigned n, len, en;
    bit          got;
    bit          q[$];

    pay = (f_op == 2'b11) ? 8'hFF : f_din;
    case (f_op)
      2'b00:   ref_wa = f_din;
      2'b01:   ref_mem[ref_wa] = f_din;
      2'b10:   ref_ra = f_din;
      default: ref_rd = ref_mem[ref_ra];
    endcase
    rd_exp = ref_rd;

    len = (f_op == 2'b11) ? 20 + RXD : 12;
    en  = len + GAP + 1;

    q.push_back(f_op[1]);
    q.push_back(f_op[1]);
    q.push_back(f_op[0]);
    for (int i = 7; i >= 0; i--) q.push_back(pay[i]);
    if (f_op == 2'b11)
      for (int i = 0; i < int'(RXD) + 8; i++) q.push_back(1'b1);
    q.push_back(1'b0);

    ss_e = '0; mo_e = '0; dn_e = '0; bz_e = '0;
    for (int i = 0; i < q.size(); i++) mo_e[i] = q[i];
    for (int i = int'(len); i < int'(en); i++) ss_e[i] = 1'b1;
    dn_e[len] = 1'b1;
    for (int i = 0; i < int'(len + GAP); i++) bz_e[i] = 1'b1;

    ss_v = '0; mo_v = '0; dn_v = '0; bz_v = '0;
    rd_done = 'x;
    got = 1'b0;
    n = 0;

    @(negedge clk);
    start = 1'b1;
    op    = f_op;
    din   = f_din;
    for (int k = 0; k < 64; k++) begin
      @(posedge clk);
      #1;
      ss_v[k] = SS_n;
      if (SS_n === 1'b0) mo_v[k] = MOSI;
      dn_v[k] = done;
      bz_v[k] = busy;
      if (done === 1'b1 && !got) begin
        rd_done = rd_data;
        got     = 1'b1;
      end
      n = k + 1;
      if (busy !== 1'b1) break;
      if (!keep) start = 1'b0;
      op  = 2'($urandom);
      din = 8'($urandom);
    end
    if (!keep) start = 1'b0;

    chk($sformatf("len op%0d", f_op),  64'(n), 64'(en));
    chk($sformatf("ss_n op%0d", f_op), ss_v, ss_e);
    chk($sformatf("mosi op%0d", f_op), mo_v, mo_e);
    chk($sformatf("done op%0d", f_op), dn_v, dn_e);
    chk($sformatf("busy op%0d", f_op), bz_v, bz_e);
    chk($sformatf("rd_at_done op%0d", f_op), 64'(rd_done), 64'(rd_exp));
    chk($sformatf("rd_hold op%0d", f_op),    64'(rd_data), 64'(rd_exp));
  endtask

  initial begin
    logic [1:0] r_op;
    logic [7:0] r_din;
    bit         seen;

    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    rst_n = 1'b0;
    start = 1'b0;
    op    = '0;
    din   = '0;

    // Reset state
    repeat (5) @(posedge clk);
    #1;
    chk("rst ss_n",    64'(SS_n),    64'(1));
    chk("rst mosi",    64'(MOSI),    64'(0));
    chk("rst busy",    64'(busy),    64'(0));
    chk("rst done",    64'(done),    64'(0));
    chk("rst rd_data", 64'(rd_data), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed frames
    run_frame(2'b00, 8'd100, 1'b0);
    run_frame(2'b01, 8'd11,  1'b0);
    run_frame(2'b10, 8'd100, 1'b0);
    run_frame(2'b11, 8'd0,   1'b0);

    // Fill addresses 100..199, then read each back
    for (int k = 0; k < 100; k++) begin
      run_frame(2'b00, 8'(100 + k), 1'b0);
      run_frame(2'b01, 8'((11 * (k + 1)) % 256), 1'b0);
    end
    for (int k = 0; k < 100; k++) begin
      run_frame(2'b10, 8'(100 + k), 1'b0);
      run_frame(2'b11, 8'($urandom), 1'b0);
    end

    // start held high throughout: one frame per acceptance
    run_frame(2'b00, 8'($urandom), 1'b1);
    run_frame(2'b01, 8'($urandom), 1'b1);
    run_frame(2'b10, 8'(100 + $urandom_range(99)), 1'b1);
    run_frame(2'b11, 8'($urandom), 1'b1);
    run_frame(2'b01, 8'($urandom), 1'b0);

    // Reset during SHIFT count 5
    @(negedge clk);
    start = 1'b1;
    op    = 2'b01;
    din   = 8'($urandom);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    ref_rd = '0;
    chk("abort ss_n",    64'(SS_n),    64'(1));
    chk("abort done",    64'(done),    64'(0));
    chk("abort busy",    64'(busy),    64'(0));
    chk("abort mosi",    64'(MOSI),    64'(0));
    chk("abort rd_data", 64'(rd_data), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) seen = 1'b1;
    end
    chk("abort no_done", 64'(seen), 64'(0));
    run_frame(2'b11, 8'($urandom), 1'b0);

    // Randomized request mix
    for (int i = 0; i < 60; i++) begin
      r_op  = 2'($urandom);
      r_din = (r_op == 2'b10) ? 8'(100 + $urandom_range(99)) : 8'($urandom);
      run_frame(r_op, r_din, 1'($urandom_range(1)));
    end
    start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
